// File: rtl/aliens_pkg.sv
// Shared definitions for the alien formation and its march controller:
// motion command codes and the march FSM state encoding.
package aliens_pkg;

    // Motion command codes, shared with the formation block
    localparam logic [1:0] MOTION_NONE = 2'd0;
    localparam logic [1:0] LEFT        = 2'd1;
    localparam logic [1:0] RIGHT       = 2'd2;
    localparam logic [1:0] DOWN        = 2'd3;

    // March FSM states
    typedef enum logic [2:0] {
        ST_RIGHT  = 3'd0,
        ST_DOWN_R = 3'd1,
        ST_LEFT   = 3'd2,
        ST_DOWN_L = 3'd3,
        ST_HALT   = 3'd4
    } marchStateT;

endpackage

// File: rtl/march_tick_gen.sv
// Programmable march tick divider. The period shrinks by a fixed step on
// every kill (rising edge of killingAlien) and saturates at a floor.
module march_tick_gen #(
    parameter int PERIOD_INIT = 2_000_000,
    parameter int PERIOD_MIN  = 200_000,
    parameter int PERIOD_DEC  = 50_000,
    parameter int CNT_W       = 22
) (
    input  logic clk,
    input  logic reset,
    input  logic hold,
    input  logic killingAlien,
    output logic tick
);
    import aliens_pkg::*;

    localparam int SUM_W = CNT_W + 1;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period;
    logic             killPrev;
    logic             killEdge;

    // Saturating period reduction; compared one bit wider so the floor+step sum cannot wrap
    function automatic logic [CNT_W-1:0] satDec(input logic [CNT_W-1:0] p);
        logic [SUM_W-1:0] floorPlusDec;
        floorPlusDec = SUM_W'(PERIOD_MIN) + SUM_W'(PERIOD_DEC);
        if ({1'b0, p} >= floorPlusDec)
            satDec = p - CNT_W'(PERIOD_DEC);
        else
            satDec = CNT_W'(PERIOD_MIN);
    endfunction

    // >= rather than == so a period shrinking below cnt still yields a tick
    assign tick     = (cnt >= (period - CNT_W'(1)));
    assign killEdge = killingAlien & ~killPrev;

    // Counter, period and kill edge detector; all frozen once the march is halted
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            period   <= CNT_W'(PERIOD_INIT);
            killPrev <= 1'b0;
        end else if (!hold) begin
            killPrev <= killingAlien;
            cnt      <= tick ? '0 : cnt + CNT_W'(1);
            if (killEdge)
                period <= satDec(period);
        end
    end

endmodule

// File: rtl/aliens_march_ctrl.sv
// March controller for the alien formation: paces the formation with the tick
// divider and sequences RIGHT / DOWN / LEFT / DOWN moves until victory or defeat.
module aliens_march_ctrl #(
    parameter int PERIOD_INIT = 2_000_000,
    parameter int PERIOD_MIN  = 200_000,
    parameter int PERIOD_DEC  = 50_000,
    parameter int DOWN_STEPS  = 15,
    parameter int CNT_W       = 22
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       canLeft,
    input  logic       canRight,
    input  logic       killingAlien,
    input  logic       victory,
    input  logic       defeat,
    output logic [1:0] motion,
    output logic       halted
);
    import aliens_pkg::*;

    localparam int DCW = $clog2(DOWN_STEPS + 1);

    marchStateT       state;
    marchStateT       stateNext;
    logic [DCW-1:0]   downCnt;
    logic [DCW-1:0]   downCntNext;
    logic [1:0]       motionNext;
    logic             tick;
    logic             stop;

    assign stop = victory | defeat;

    march_tick_gen #(
        .PERIOD_INIT (PERIOD_INIT),
        .PERIOD_MIN  (PERIOD_MIN),
        .PERIOD_DEC  (PERIOD_DEC),
        .CNT_W       (CNT_W)
    ) tickGen (
        .clk          (clk),
        .reset        (reset),
        .hold         (state == ST_HALT),
        .killingAlien (killingAlien),
        .tick         (tick)
    );

    // State and DOWN-step counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_RIGHT;
            downCnt <= '0;
        end else begin
            state   <= stateNext;
            downCnt <= downCntNext;
        end
    end

    // Next-state logic: halt overrides everything, otherwise advance only on a tick
    always_comb begin
        stateNext   = state;
        downCntNext = downCnt;
        if (stop) begin
            stateNext = ST_HALT;
        end else if (tick) begin
            case (state)
                ST_RIGHT: begin
                    if (!canRight) begin
                        stateNext   = ST_DOWN_R;
                        downCntNext = DCW'(DOWN_STEPS);
                    end
                end
                ST_DOWN_R: begin
                    downCntNext = downCnt - DCW'(1);
                    if (downCnt == DCW'(1))
                        stateNext = ST_LEFT;
                end
                ST_LEFT: begin
                    if (!canLeft) begin
                        stateNext   = ST_DOWN_L;
                        downCntNext = DCW'(DOWN_STEPS);
                    end
                end
                ST_DOWN_L: begin
                    downCntNext = downCnt - DCW'(1);
                    if (downCnt == DCW'(1))
                        stateNext = ST_RIGHT;
                end
                default: ;
            endcase
        end
    end

    // Motion command for the coming cycle; the reversal tick itself stays idle
    always_comb begin
        motionNext = MOTION_NONE;
        if (!stop && tick) begin
            case (state)
                ST_RIGHT:  if (canRight) motionNext = RIGHT;
                ST_LEFT:   if (canLeft)  motionNext = LEFT;
                ST_DOWN_R: motionNext = DOWN;
                ST_DOWN_L: motionNext = DOWN;
                default:   motionNext = MOTION_NONE;
            endcase
        end
    end

    // Registered single-cycle motion pulse and halted flag
    always_ff @(posedge clk) begin
        if (reset) begin
            motion <= MOTION_NONE;
            halted <= 1'b0;
        end else begin
            motion <= motionNext;
            halted <= (stateNext == ST_HALT);
        end
    end

endmodule

// File: doc/aliens_march_ctrl.md
# aliens_march_ctrl

Generates the `motion` command stream that drives the alien formation block, using its `canLeft`, `canRight`, `killingAlien`, `victory` and `defeat` outputs as feedback. It paces the formation with a programmable tick divider and marches it right, then down, then left, then down, repeating. The march speeds up with every kill and freezes for good on victory or defeat. It sits directly upstream of the alien formation block, and its `motion` output connects straight to that block's `motion` input.

## Interface
- `PERIOD_INIT`, 2_000_000: initial march period, in clk cycles per tick.
- `PERIOD_MIN`, 200_000: floor for the period.
- `PERIOD_DEC`, 50_000: period reduction per kill.
- `DOWN_STEPS`, 15: DOWN pulses per edge reversal. Must be ≥1.
- `CNT_W`, 22: width of the tick counter and the period register. All period values must fit in it.
- `clk`  in  1  system clock. The design has one clock.
- `reset`  in  1  synchronous, active-high reset.
- `canLeft`  in  1  the formation may step left.
- `canRight`  in  1  the formation may step right.
- `killingAlien`  in  1  kill indicator. It is edge-detected, so a held level counts once.
- `victory`  in  1  all aliens are dead.
- `defeat`  in  1  the formation has reached the bottom limit.
- `motion`  out  2  motion command: 0 = none, 1 = LEFT, 2 = RIGHT, 3 = DOWN. Each non-zero value is a single-cycle pulse.
- `halted`  out  1  high once the block is in HALT.

## Operation
- **Tick divider**
  - `cnt` counts from 0.
  - `tick` = (`cnt` ≥ `period`−1).
  - On `tick`, `cnt` returns to 0. Otherwise `cnt` increments.
  - The ≥ comparison guarantees a tick even if `period` shrinks below the current `cnt`.
- **Speed-up**
  - `killPrev` holds the previous value of `killingAlien`.
  - On a rising edge (`killingAlien` & ~`killPrev`): `period` ← max(`period`−`PERIOD_DEC`, `PERIOD_MIN`).
  - The subtraction is done unsigned and saturating. There is no underflow wrap.
- **FSM states**: RIGHT, DOWN_R, LEFT, DOWN_L, HALT.
- **Transitions on a tick**
  - RIGHT with `canRight`=1: emit RIGHT.
  - RIGHT with `canRight`=0: emit nothing, load `downCnt` ← `DOWN_STEPS`, go to DOWN_R.
  - DOWN_R: emit DOWN and decrement `downCnt`. When `downCnt`==1 before the decrement, go to LEFT.
  - LEFT and DOWN_L mirror the above using `canLeft`; DOWN_L exits to RIGHT.
- Each reversal therefore produces exactly `DOWN_STEPS` DOWN pulses and costs one idle tick.
- **HALT**
  - Entered from any state in the cycle after `victory` or `defeat` is sampled high.
  - HALT takes priority over tick and kill processing.
  - In HALT, `motion`=0 and `halted`=1. HALT is left only by `reset`.
- **Between ticks**: `motion`=0.

## Timing
- **Reset values**
  - `motion`=0, `halted`=0, `cnt`=0, `period`=`PERIOD_INIT`, `downCnt`=0, `killPrev`=0, state=RIGHT.
- Reset asserted mid-march or mid-DOWN sequence restores these values on the next edge. The first tick then arrives `PERIOD_INIT` cycles after reset deasserts.
- `motion` is registered.
  - The pulse is visible in the cycle after the edge on which `tick` was true.
  - The pulse lasts exactly 1 cycle.
- `canLeft`/`canRight` are sampled on the tick edge only. The one-cycle-stale values from the formation block are acceptable because ticks are ≥`PERIOD_MIN` apart.
- **Simultaneous kill and tick**: the period update applies from the next `cnt` comparison. The current tick still fires.
- **Simultaneous `victory`/`defeat` and tick**: HALT wins and no motion is emitted.
- **`halted`**: registered, rising 1 cycle after the `victory`/`defeat` sample.

## Structure
- Shared package `aliens_pkg`:
  - motion codes `MOTION_NONE`=0, `LEFT`=1, `RIGHT`=2, `DOWN`=3, shared with the formation block;
  - the FSM state encoding (3 bits).
- Sub-module `march_tick_gen`: owns `cnt`, `period`, kill edge-detect and saturation, and outputs `tick`.
- The top level holds the FSM, `downCnt` and the `motion`/`halted` registers.

## Test plan
Unless noted, benches use `PERIOD_INIT`=8, `PERIOD_MIN`=2, `PERIOD_DEC`=3, `DOWN_STEPS`=3.
- **Basic march**: reset, `canRight`=1, no kills → `motion`=2 for one cycle every 8 cycles, 0 otherwise; first pulse 8 cycles after reset release.
- **Right-edge reversal**: drop `canRight` to 0 → one idle tick, then exactly 3 DOWN pulses on consecutive ticks, then LEFT pulses while `canLeft`=1.
- **Speed-up and saturation**: three `killingAlien` rising edges, each held 2 cycles → `period` goes 8, 5, 2, 2; tick spacing becomes 2 cycles with no missed tick.
- **Period shrink while counting**: kill at `cnt`=6 with `period` 8→5 → tick fires on the next edge, then spacing is 5.
- **Halt**: pulse `defeat` in the same cycle as a tick → no motion pulse, `halted`=1 next cycle, `motion` stays 0 for ≥100 cycles; repeat with `victory` for the same result.
- **Reset mid-DOWN**: assert `reset` after the 1st DOWN pulse → state RIGHT, `period`=8, next pulse is RIGHT 8 cycles after release.
